rr_arbiter: RTL and testbench

Parametrised N-writer round-robin arbiter feeding a single FIFO write port; next generation of the two-writer fixed-priority arbiter. It selects one requesting writer per grant, captures that writer's word and pushes it into the downstream FIFO with `o_we`. It adds fairness, FIFO backpressure, a writer-ID tag on the output, and back-to-back grants. It sits between the writer modules and the shared FIFO.

---
 rtl/rr_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// N-writer round-robin arbiter feeding one FIFO write port with an ID tag.
// Define RR_ARBITER_FIXED_PRIO_EN to swap round-robin for lowest-index-wins priority.
module rr_arbiter #(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_W      = 8,
  parameter int ID_W        = $clog2(NUM_WRITERS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_WRITERS*DATA_W-1:0] i_data,
  input  logic [NUM_WRITERS-1:0]        i_req,
  input  logic                          i_full,
  output logic [NUM_WRITERS-1:0]        o_busy,
  output logic [DATA_W-1:0]             o_data,
  output logic [ID_W-1:0]               o_id,
  output logic                          o_we,
  output logic                          dbg_state
);

  // Writer handshake: a writer holds i_req and its word while its o_busy bit is 1;
  // the word is taken in the single cycle that bit is 0, and the writer may only
  // drop i_req or change data after seeing that 0.

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state;
  logic [ID_W-1:0]         last;      // current winner while in GRANT; scan origin for round-robin
  logic [NUM_WRITERS-1:0]  masked;
  logic                    found;
  logic [ID_W-1:0]         nxt;
  logic [ID_W-1:0]         scan;
  logic [DATA_W-1:0]       cur_word;
  logic [NUM_WRITERS-1:0]  busy_nxt;

  assign dbg_state = (state == GRANT);

  // The writer holding the grant is excluded from the next pick.
  always_comb begin
    masked = i_req;
    if (state == GRANT) masked[last] = 1'b0;
  end

`ifdef RR_ARBITER_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    scan  = '0;
    for (int j = 0; j < NUM_WRITERS; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        nxt   = ID_W'(j);
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    scan  = last;
    for (int k = 0; k < NUM_WRITERS; k++) begin
      scan = (scan == ID_W'(NUM_WRITERS - 1)) ? '0 : scan + ID_W'(1);
      if (!found && masked[scan]) begin
        found = 1'b1;
        nxt   = scan;
      end
    end
  end
`endif

  always_comb begin
    cur_word = '0;
    for (int j = 0; j < NUM_WRITERS; j++) begin
      if (last == ID_W'(j)) cur_word = i_data[j*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    busy_nxt      = '1;
    busy_nxt[nxt] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      o_busy <= '1;
      o_we   <= 1'b0;
      o_data <= '0;
      o_id   <= '0;
      last   <= ID_W'(NUM_WRITERS - 1);
    end else begin
      o_we <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !i_full) begin
            state  <= GRANT;
            o_busy <= busy_nxt;
            last   <= nxt;
          end
        end
        GRANT: begin
          // Leaving GRANT always writes; i_full only blocks the next grant.
          o_we   <= 1'b1;
          o_data <= cur_word;
          o_id   <= last;
          if (found && !i_full) begin
            o_busy <= busy_nxt;
            last   <= nxt;
          end else begin
            state  <= IDLE;
            o_busy <= '1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (4 writers, 8-bit words) with immediate assertions
// and a background invariant monitor.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] data_bus;
  logic [N-1:0]    req;
  logic            full;
  logic [N-1:0]    busy;
  logic [DW-1:0]   wdata;
  logic [IW-1:0]   wid;
  logic            we;
  logic            st;

  int checks;
  int fails;
  bit rst_seen;

  rr_arbiter #(.NUM_WRITERS(N), .DATA_W(DW), .ID_W(IW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_data    (data_bus),
    .i_req     (req),
    .i_full    (full),
    .o_busy    (busy),
    .o_data    (wdata),
    .o_id      (wid),
    .o_we      (we),
    .dbg_state (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic set_words(input logic [DW-1:0] base);
    for (int j = 0; j < N; j++) data_bus[j*DW +: DW] = base + DW'(j);
  endtask

  // Invariants sampled after every edge: one-hot-or-zero grant, and o_data/o_id
  // move only together with a write strobe.
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;
  always @(negedge rst_n) rst_seen = 1'b1;
  always @(posedge clk) begin
    #2;
    check("busy_onehot0", 32'($countones(~busy) <= 1), 32'd1);
    if (rst_n && !rst_seen && !we) begin
      check("data_hold", 32'(wdata), 32'(prev_data));
      check("id_hold", 32'(wid), 32'(prev_id));
    end
    rst_seen  = 1'b0;
    prev_data = wdata;
    prev_id   = wid;
  end

  // Grant order with all four writers requesting from reset.
`ifdef RR_ARBITER_FIXED_PRIO_EN
  int all_order[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
  int all_order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif
  int alt_order[4] = '{1, 3, 1, 3};

  initial begin
    checks   = 0;
    fails    = 0;
    rst_seen = 1'b1;
    rst_n    = 1'b0;
    req      = '0;
    full     = 1'b0;
    data_bus = '0;
    #12 rst_n = 1'b1;

    // Reset values
    #1;
    check("rst_busy", 32'(busy), 32'hF);
    check("rst_we", 32'(we), 32'd0);
    check("rst_data", 32'(wdata), 32'd0);
    check("rst_id", 32'(wid), 32'd0);
    check("rst_state", 32'(st), 32'd0);

    // Writer 2 alone
    step();
    data_bus[2*DW +: DW] = 8'h5A;
    req = 4'b0100;
    step();
    check("solo_busy", 32'(busy), 32'hB);
    check("solo_we0", 32'(we), 32'd0);
    req = 4'b0000;
    step();
    check("solo_we", 32'(we), 32'd1);
    check("solo_data", 32'(wdata), 32'h5A);
    check("solo_id", 32'(wid), 32'd2);
    check("solo_idle_busy", 32'(busy), 32'hF);
    step();
    check("solo_we_end", 32'(we), 32'd0);
    check("solo_state_end", 32'(st), 32'd0);

    // All writers requesting continuously
    do_reset();
    set_words(8'h10);
    req = 4'b1111;
    step();
    check("all_first_busy", 32'(busy), 32'hF & ~(32'd1 << all_order[0]));
    for (int k = 1; k <= 8; k++) begin
      step();
      check("all_we", 32'(we), 32'd1);
      check("all_id", 32'(wid), 32'(all_order[k-1]));
      check("all_data", 32'(wdata), 32'h10 + 32'(all_order[k-1]));
      check("all_busy", 32'(busy), 32'hF & ~(32'd1 << all_order[k]));
    end
    req = 4'b0000;
    step();
    check("all_last_we", 32'(we), 32'd1);
    check("all_last_id", 32'(wid), 32'(all_order[8]));
    check("all_last_busy", 32'(busy), 32'hF);
    step();
    check("all_tail_we", 32'(we), 32'd0);

    // Backpressure
    do_reset();
    set_words(8'h10);
    full = 1'b1;
    req  = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      step();
      check("full_busy", 32'(busy), 32'hF);
      check("full_we", 32'(we), 32'd0);
    end
    full = 1'b0;
    step();
    check("unfull_busy", 32'(busy), 32'hD);
    full = 1'b1;
    step();
    check("fullrise_we", 32'(we), 32'd1);
    check("fullrise_id", 32'(wid), 32'd1);
    check("fullrise_data", 32'(wdata), 32'h11);
    check("fullrise_busy", 32'(busy), 32'hF);
    step();
    check("fullrise_we_end", 32'(we), 32'd0);
    req  = 4'b0000;
    full = 1'b0;

    // Reset mid-grant
    do_reset();
    req = 4'b1111;
    step();
    check("pre_rst_busy", 32'(busy), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'hF);
    check("async_we", 32'(we), 32'd0);
    check("async_state", 32'(st), 32'd0);
    check("async_data", 32'(wdata), 32'd0);
    step();
    check("inrst_we", 32'(we), 32'd0);
    check("inrst_busy", 32'(busy), 32'hF);
    #4 rst_n = 1'b1;
    #1;
    check("post_rst_we", 32'(we), 32'd0);
    step();
    check("post_rst_busy", 32'(busy), 32'hE);
    req = 4'b0000;
    step();
    check("post_rst_we1", 32'(we), 32'd1);
    check("post_rst_id", 32'(wid), 32'd0);
    check("post_rst_data", 32'(wdata), 32'h10);
    step();

    // Writers 1 and 3 alternate
    do_reset();
    set_words(8'h10);
    data_bus[3*DW +: DW] = 8'h33;
    req = 4'b1010;
    step();
    check("alt_busy", 32'(busy), 32'hD);
    for (int k = 0; k < 4; k++) begin
      step();
      check("alt_we", 32'(we), 32'd1);
      check("alt_id", 32'(wid), 32'(alt_order[k]));
      check("alt_data", 32'(wdata), (alt_order[k] == 1) ? 32'h11 : 32'h33);
    end
    req = 4'b0000;
    step();
    step();
    check("alt_end_we", 32'(we), 32'd0);
    check("alt_end_busy", 32'(busy), 32'hF);

    #3;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
